// File: rtl/cfg_pkg.sv
// Shared configuration-loader types and constants, plus the I2C responder state set.
package cfg_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam logic [6:0]  SLAVE_ADDR = 7'h74;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } r_w;

  typedef enum logic [3:0] {
    IDLE,
    DEV_RX,
    AHI_RX,
    ALO_RX,
    WR_RX,
    RD_TX,
    RD_ACK,
    ACK,
    IGNORE
  } i2c_resp_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// Optional I2C_RESP_GLITCH_FILTER_EN adds a FILTER_CYCLES stability filter per line.
module i2c_line_sync #(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [1:0] scl_meta, sda_meta;
  logic       scl_f, sda_f;
  logic       scl_prev, sda_prev;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_meta <= 2'b11;
      sda_meta <= 2'b11;
    end else begin
      scl_meta <= {scl_meta[0], scl_i};
      sda_meta <= {sda_meta[0], sda_i};
    end
  end

`ifdef I2C_RESP_GLITCH_FILTER_EN
  localparam int unsigned CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES + 1) : 1;
  logic [CW-1:0] scl_cnt, sda_cnt;

  // A line adopts a new level only after it has held it for FILTER_CYCLES samples.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_meta[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_CYCLES - 1)) begin
        scl_f   <= scl_meta[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CW'(1);
      end
      if (sda_meta[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_CYCLES - 1)) begin
        sda_f   <= sda_meta[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CW'(1);
      end
    end
  end
`else
  assign scl_f = scl_meta[1];
  assign sda_f = sda_meta[1];
`endif

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  assign sda        = sda_f;
  assign scl_rise_c = scl_f & ~scl_prev;
  assign scl_fall_c = ~scl_f & scl_prev;
  assign start_c    = scl_f & scl_prev & sda_prev & ~sda_f;
  assign stop_c     = scl_f & scl_prev & ~sda_prev & sda_f;

endmodule

// File: rtl/i2c_cfg_responder.sv
// I2C target with a 16-bit-addressed byte register file and a fabric write mirror.
// Build option I2C_RESP_GLITCH_FILTER_EN enables the input glitch filter.
module i2c_cfg_responder
  import cfg_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR      = SLAVE_ADDR,
  parameter int unsigned REG_DEPTH     = 1024,
  parameter string       INIT_FILE     = "",
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oen_o,
  output logic        wr_en_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  input  logic [15:0] rd_addr_i,
  output logic [7:0]  rd_data_o,
  output logic        busy_o
);

  localparam int unsigned AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam int unsigned DW = DATA_WIDTH;

  i2c_resp_state_t state_q, state_d, after_q, after_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   shift_q, shift_d, tx_q, tx_d;
  logic [15:0]     ptr_q, ptr_d;
  logic            oen_q, oen_d, wr_en_q, wr_en_d, busy_q, busy_d;
  logic [15:0]     wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            mem_we_c;

  logic            sda, scl_rise_c, scl_fall_c, start_c, stop_c;
  logic [DW-1:0]   rx_byte_c, rd_byte_c;
  logic            ptr_ok_c;
  logic [DW-1:0]   mem [REG_DEPTH];

  i2c_line_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda        (sda),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  assign rx_byte_c = {shift_q[DW-2:0], sda};
  assign ptr_ok_c  = 32'(ptr_q) < REG_DEPTH;
  assign rd_byte_c = ptr_ok_c ? mem[ptr_q[AW-1:0]] : '0;
  assign rd_data_o = (32'(rd_addr_i) < REG_DEPTH) ? mem[rd_addr_i[AW-1:0]] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (mem_we_c) mem[ptr_q[AW-1:0]] <= rx_byte_c;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= IDLE;
      after_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      oen_q     <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      after_q   <= after_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      oen_q     <= oen_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    after_d   = after_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    oen_d     = oen_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    mem_we_c  = 1'b0;

    if (stop_c) begin
      state_d   = IDLE;
      oen_d     = 1'b1;
      busy_d    = 1'b0;
      bit_cnt_d = '0;
    end else if (start_c) begin
      state_d   = DEV_RX;
      oen_d     = 1'b1;
      busy_d    = 1'b1;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        DEV_RX, AHI_RX, ALO_RX, WR_RX: begin
          if (scl_rise_c) begin
            shift_d   = rx_byte_c;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              state_d   = ACK;
              case (state_q)
                DEV_RX: begin
                  if (rx_byte_c[7:1] == DEV_ADDR)
                    after_d = (r_w'(rx_byte_c[0]) == READ) ? RD_TX : AHI_RX;
                  else
                    state_d = IGNORE;
                end
                AHI_RX: begin
                  ptr_d[15:8] = rx_byte_c;
                  after_d     = ALO_RX;
                end
                ALO_RX: begin
                  ptr_d[7:0] = rx_byte_c;
                  after_d    = WR_RX;
                end
                default: begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = ptr_q;
                  wr_data_d = rx_byte_c;
                  mem_we_c  = ptr_ok_c;
                  ptr_d     = ptr_q + 16'd1;
                  after_d   = WR_RX;
                end
              endcase
            end
          end
        end
        // First fall after bit 8 drives the ACK, the next one ends it.
        ACK: begin
          if (scl_fall_c) begin
            if (oen_q) begin
              oen_d = 1'b0;
            end else begin
              state_d   = after_q;
              bit_cnt_d = '0;
              oen_d     = 1'b1;
              if (after_q == RD_TX) begin
                oen_d     = rd_byte_c[DW-1];
                tx_d      = {rd_byte_c[DW-2:0], 1'b0};
                bit_cnt_d = 4'd1;
              end
            end
          end
        end
        // bit_cnt counts bits already presented; 0 means the byte is not loaded yet.
        RD_TX: begin
          if (scl_fall_c) begin
            if (bit_cnt_q == 4'd0) begin
              oen_d     = rd_byte_c[DW-1];
              tx_d      = {rd_byte_c[DW-2:0], 1'b0};
              bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              oen_d     = 1'b1;
              state_d   = RD_ACK;
              bit_cnt_d = '0;
            end else begin
              oen_d     = tx_q[DW-1];
              tx_d      = {tx_q[DW-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise_c) begin
            if (!sda) begin
              ptr_d   = ptr_q + 16'd1;
              state_d = RD_TX;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oen_o = oen_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign busy_o    = busy_q;

endmodule
